// File: rtl/tf_tanh_sched.sv
// tf_tanh_sched: sequences the shared tf_tanh unit across the reservoir state.
// A start pulse streams NBATCH rows of NIN accumulator words through tf_tanh.
// The 16-bit activations are written to the state RAM, and then done pulses.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             run request, sampled only while idle
//   busy / done       run in progress / one-cycle completion pulse
//   rd_en/rd_addr     accumulator RAM read (data returns one cycle later)
//   rd_data           accumulator RAM row, NIN x WORDLEN
//   tf_ibus/tf_obus   tf_tanh input (zero when idle) / output (NIN x 16)
//   wr_en/wr_addr     state RAM write strobe and row address
//   wr_data           activations, lane i = tf_obus[16*i+15:16*i]

// Per-lane datapath. It gates a RAM word onto IBUS and captures the OBUS
// activation for the write.
module tf_tanh_sched_lane #(
    parameter int WORDLEN = 38
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ibus_en,
    input  logic [WORDLEN-1:0] rd_word,
    output logic [WORDLEN-1:0] ibus_word,
    input  logic               wr_take,
    input  logic [15:0]        obus_word,
    output logic [15:0]        wr_word
);
    always_ff @(posedge clk) begin
        if (rst) begin
            ibus_word <= '0;
            wr_word   <= '0;
        end else begin
            ibus_word <= ibus_en ? rd_word : '0;
            wr_word   <= wr_take ? obus_word : '0;
        end
    end
endmodule

module tf_tanh_sched #(
    parameter int WORDLEN = 38,
    parameter int NIN     = 4,
    parameter int NBATCH  = 16,
    parameter int TF_LAT  = 2,
    parameter int AW      = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   rd_en,
    output logic [AW-1:0]          rd_addr,
    input  logic [WORDLEN*NIN-1:0] rd_data,
    output logic [WORDLEN*NIN-1:0] tf_ibus,
    input  logic [16*NIN-1:0]      tf_obus,
    output logic                   wr_en,
    output logic [AW-1:0]          wr_addr,
    output logic [16*NIN-1:0]      wr_data
);
    // vld_pipe[j] is high in cycle k+1+j for a read issued in cycle k.
    // [0] marks rd_data valid, [1] marks tf_ibus valid, and [STAGES] marks
    // tf_obus valid.
    localparam int STAGES = TF_LAT + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                  state, state_nxt;
    logic [STAGES:0]         vld_pipe;
    logic [STAGES:0][AW-1:0] addr_pipe;
    logic                    last_rd;
    logic                    pipe_empty;

    assign last_rd    = (rd_addr == AW'(NBATCH - 1));
    assign pipe_empty = ~|vld_pipe;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ISSUE;
            ISSUE:   if (last_rd) state_nxt = DRAIN;
            // The final write is in flight when the pipe has emptied behind it.
            DRAIN:   if (wr_en && pipe_empty) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The outputs are decoded from the next state so that they are registered
    // in step with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            vld_pipe  <= '0;
            addr_pipe <= '0;
        end else begin
            busy      <= (state_nxt == ISSUE) || (state_nxt == DRAIN);
            done      <= (state_nxt == DONE);
            rd_en     <= (state_nxt == ISSUE);
            rd_addr   <= (state == ISSUE && !last_rd) ? rd_addr + AW'(1) : '0;
            vld_pipe  <= {vld_pipe[STAGES-1:0], rd_en};
            addr_pipe <= {addr_pipe[STAGES-1:0], rd_addr};
            wr_en     <= vld_pipe[STAGES];
            wr_addr   <= vld_pipe[STAGES] ? addr_pipe[STAGES] : '0;
        end
    end

    for (genvar i = 0; i < NIN; i++) begin : g_lane
        tf_tanh_sched_lane #(.WORDLEN(WORDLEN)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .ibus_en   (vld_pipe[0]),
            .rd_word   (rd_data[WORDLEN*i +: WORDLEN]),
            .ibus_word (tf_ibus[WORDLEN*i +: WORDLEN]),
            .wr_take   (vld_pipe[STAGES]),
            .obus_word (tf_obus[16*i +: 16]),
            .wr_word   (wr_data[16*i +: 16])
        );
    end
endmodule

// File: tb/tb_tf_tanh_sched.sv
// Directed bench for tf_tanh_sched.
// Instance u0 uses the default parameters and a 2-cycle tf_tanh model.
// Instance u1 uses NBATCH=1 and TF_LAT=0 with a combinational model.
module tb_tf_tanh_sched;
    logic         clk = 1'b0;
    logic         rst;
    logic         start, start1;

    logic         busy, done, rd_en, wr_en;
    logic [3:0]   rd_addr, wr_addr;
    logic [151:0] rd_data, tf_ibus;
    logic [63:0]  tf_obus, wr_data;

    logic         busy1, done1, rd_en1, wr_en1;
    logic [0:0]   rd_addr1, wr_addr1;
    logic [151:0] rd_data1, tf_ibus1;
    logic [63:0]  tf_obus1, wr_data1;

    logic [151:0] mem [16];
    logic [63:0]  ob1, ob2;

    int n_asrt = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tf_tanh_sched u0 (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .tf_ibus(tf_ibus), .tf_obus(tf_obus),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    tf_tanh_sched #(.NBATCH(1), .TF_LAT(0), .AW(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .tf_ibus(tf_ibus1), .tf_obus(tf_obus1),
        .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1)
    );

    // Each lane's activation is the top 16 bits of its 38-bit word.
    function automatic logic [63:0] top16(input logic [151:0] ib);
        logic [63:0] o;
        for (int i = 0; i < 4; i++) o[16*i +: 16] = ib[38*i + 22 +: 16];
        return o;
    endfunction

    function automatic logic [151:0] row(input int v);
        logic [37:0] w;
        w = 38'(v) << 22;
        return {4{w}};
    endfunction

    // Accumulator RAM models and tf_tanh models.
    always @(posedge clk) begin
        if (rd_en)  rd_data  <= mem[rd_addr];
        if (rd_en1) rd_data1 <= row(7);
        ob1 <= top16(tf_ibus);
        ob2 <= ob1;
    end
    assign tf_obus  = ob2;
    assign tf_obus1 = top16(tf_ibus1);

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int runs, first2, dcnt, d1, d2, stray;
    logic prev;

    initial begin
        rst = 1'b1; start = 1'b0; start1 = 1'b0;
        for (int r = 0; r < 16; r++) mem[r] = row(r + 1);
        repeat (3) step();
        rst = 1'b0;

        // Idle after reset.
        for (int n = 1; n <= 10; n++) begin
            step();
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
            chk("idle_rd_en", rd_en, 0);
            chk("idle_wr_en", wr_en, 0);
            chk("idle_ibus", tf_ibus, 0);
            chk("idle_u1", {busy1, done1, rd_en1, wr_en1}, 0);
        end

        // Single run at the default parameters.
        start = 1'b1; step(); start = 1'b0;
        for (int n = 1; n <= 24; n++) begin
            chk("run_rd_en", rd_en, (n <= 16));
            chk("run_rd_addr", rd_addr, (n <= 16) ? n - 1 : 0);
            chk("run_ibus", tf_ibus, (n >= 3 && n <= 18) ? row(n - 2) : 152'd0);
            chk("run_wr_en", wr_en, (n >= 6 && n <= 21));
            chk("run_wr_addr", wr_addr, (n >= 6 && n <= 21) ? n - 6 : 0);
            chk("run_wr_data", wr_data, (n >= 6 && n <= 21) ? {4{16'(n - 5)}} : 64'd0);
            chk("run_done", done, (n == 22));
            chk("run_busy", busy, (n <= 21));
            step();
        end
        repeat (3) step();

        // Start held high for 40 cycles: exactly two runs.
        runs = 0; first2 = 0; dcnt = 0; d1 = 0; d2 = 0; prev = 1'b0;
        start = 1'b1; step();
        for (int n = 1; n <= 60; n++) begin
            if (n == 41) start = 1'b0;
            if (rd_en && !prev) begin
                runs++;
                if (runs == 2) first2 = n;
            end
            prev = rd_en;
            if (done) begin
                dcnt++;
                if (dcnt == 1) d1 = n;
                if (dcnt == 2) d2 = n;
            end
            step();
        end
        chk("held_runs", runs, 2);
        chk("held_second_rd", first2, 24);
        chk("held_done_cnt", dcnt, 2);
        chk("held_done1", d1, 22);
        chk("held_done2", d2, 45);

        // Reset in cycle 8 aborts the run.
        start = 1'b1; step(); start = 1'b0;
        for (int n = 1; n < 8; n++) begin
            if (n == 6) chk("abort_pre_wr", {wr_en, wr_addr}, {1'b1, 4'd0});
            step();
        end
        rst = 1'b1; step(); rst = 1'b0;
        chk("abort_ctl", {busy, done, rd_en, wr_en}, 0);
        chk("abort_addr", {rd_addr, wr_addr}, 0);
        chk("abort_data", {tf_ibus, wr_data}, 0);
        stray = 0;
        for (int n = 0; n < 30; n++) begin
            step();
            if (wr_en || done || busy) stray++;
        end
        chk("abort_quiet", stray, 0);
        start = 1'b1; step(); start = 1'b0;
        for (int n = 1; n <= 22; n++) begin
            if (n == 1)  chk("rerun_rd", {rd_en, rd_addr}, {1'b1, 4'd0});
            if (n == 6)  chk("rerun_wr", {wr_en, wr_addr, wr_data}, {1'b1, 4'd0, {4{16'd1}}});
            if (n == 21) chk("rerun_nodone", done, 0);
            if (n == 22) chk("rerun_done", done, 1);
            step();
        end
        repeat (3) step();

        // Lane ordering: distinct values per lane in row 0.
        mem[0] = {38'd4 << 22, 38'd3 << 22, 38'd2 << 22, 38'd1 << 22};
        start = 1'b1; step(); start = 1'b0;
        for (int n = 1; n <= 24; n++) begin
            if (n == 3) chk("lane_ibus", tf_ibus, mem[0]);
            if (n == 6) chk("lane_wr_data", wr_data, {16'd4, 16'd3, 16'd2, 16'd1});
            step();
        end

        // NBATCH=1, TF_LAT=0 instance.
        start1 = 1'b1; step(); start1 = 1'b0;
        for (int n = 1; n <= 7; n++) begin
            chk("u1_rd", {rd_en1, rd_addr1}, {(n == 1), 1'b0});
            chk("u1_wr_en", wr_en1, (n == 4));
            chk("u1_wr_data", wr_data1, (n == 4) ? {4{16'd7}} : 64'd0);
            chk("u1_done", done1, (n == 5));
            chk("u1_busy", busy1, (n <= 4));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule

// File: doc/tf_tanh_sched.md
Name: tf_tanh_sched

Overview:
Scheduler that sequences the shared tf_tanh transfer-function unit over a full reservoir state vector held in the accumulator RAM. On a start pulse it streams NBATCH batches of NIN words from the RAM through tf_tanh and writes the 16-bit activations to the state RAM. It then pulses done. It sits between the reservoir MAC/accumulator stage and the state-update RAM, and owns tf_tanh's IBUS/OBUS.

Parameters:
WORDLEN, 38, width of one accumulator word (tf_tanh input lane)
NIN, 4, lanes per tf_tanh call (words per RAM row)
NBATCH, 16, RAM rows per run (neurons = NIN*NBATCH); must be >=1
TF_LAT, 2, tf_tanh latency in cycles, IBUS valid to OBUS valid; must be >=0
AW, 4, address width; must satisfy 2**AW >= NBATCH

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  run request, sampled only while idle
busy  out  1  high from the cycle after start is accepted through the last write
done  out  1  one-cycle pulse after the last write
rd_en  out  1  accumulator RAM read strobe
rd_addr  out  AW  accumulator RAM row address
rd_data  in  WORDLEN*NIN  RAM row, valid the cycle after rd_en
tf_ibus  out  WORDLEN*NIN  to tf_tanh IBUS
tf_obus  in  16*NIN  from tf_tanh OBUS
wr_en  out  1  state RAM write strobe
wr_addr  out  AW  state RAM row address
wr_data  out  16*NIN  activations, lane i = tf_obus[16*i+15:16*i]

Behaviour:
- All outputs are registered. Reset forces all outputs to 0, the FSM to IDLE, the valid pipe to 0 and the counters to 0. Reset mid-run aborts the run with no write and no done.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: start=1 at edge E0 -> ISSUE. Call the cycle after E0 cycle 1. While busy, start is ignored (not queued).
- ISSUE: rd_en=1 on cycles 1..NBATCH. rd_addr=0..NBATCH-1, incrementing by 1. After the issue with rd_addr=NBATCH-1 -> DRAIN.
- Read pipe: rd_data is captured into tf_ibus at the end of cycle k+1 for a read in cycle k, so tf_ibus is valid in cycle k+2.
- tf_ibus is forced to all-zeros in any cycle without a valid batch, so tf_tanh sees 0 between runs.
- Valid/address shift pipe of depth TF_LAT+2 tracks each batch. tf_obus is sampled at the end of cycle k+2+TF_LAT.
- wr_en=1 with wr_addr=k_addr and wr_data=sampled tf_obus in cycle k+3+TF_LAT.
- Write-side timing: wr_en is high on cycles TF_LAT+4 .. TF_LAT+3+NBATCH, contiguous, with wr_addr 0..NBATCH-1. wr_data=0 when wr_en=0.
- DRAIN: waits until the pipe is empty after the final write -> DONE.
- DONE: done=1 and busy=0 in cycle TF_LAT+4+NBATCH; next state IDLE.
- start=1 in the DONE cycle is ignored. start is accepted from IDLE on the following edge, giving a minimum 1 idle cycle between runs.
- Address counters do not wrap within a run. Both counters return to 0 at run end.
- NBATCH=1: single read, single write, then done.
- TF_LAT=0: the same equations apply; wr_en starts at cycle 4.
- Data is passed through unmodified. The scheduler performs no arithmetic on the data.

Test Plan:
- Reset then idle 10 cycles -> busy, done, rd_en, wr_en all 0; tf_ibus=0; start not asserted.
- Single run at defaults: RAM row r holds all lanes = (r+1)<<22; tf_tanh model is a 2-cycle delay of the top 16 bits. Required: rd_en cycles 1..16, wr_en cycles 6..21, wr_addr=r carries (r+1)<<22 >>22 truncated; done only in cycle 22; busy cycles 1..21.
- start held high for 40 cycles -> exactly two runs. Second run's rd_en begins cycle 24 (DONE at 22, IDLE at 23, accepted at the end of 23); no extra done pulses.
- rst asserted in cycle 8 of a run -> next cycle all outputs 0, no further wr_en, no done. A new start then produces a clean run from addr 0.
- NBATCH=1, TF_LAT=0 build: start -> rd_en cycle 1 addr 0, wr_en cycle 4 addr 0, done cycle 5.
- Lane ordering: row 0 lanes = 1,2,3,4 (<<22) with identity model -> wr_data lane i matches input lane i; no lane swap.
